// File: rtl/routex_egress_serializer_pkg.sv
// Shared types for the routex egress serializer: flit layout, header field
// positions and serializer FSM states.
package routex_egress_serializer_pkg;

    localparam int FLIT_W   = 512;
    localparam int LEN_WORD = 7;
    localparam int LEN_W    = 16;

    typedef logic [7:0][63:0] flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } ser_state_t;

    // Payload length carried in the low bits of header word 7.
    function automatic logic [LEN_W-1:0] flit_len(input flit_t f);
        return f[LEN_WORD][LEN_W-1:0];
    endfunction

endpackage

// File: rtl/routex_egress_serializer_if.sv
// Flit-in / word-out bundle between a routex_core output port, the egress
// serializer (slave) and the link MAC side.
interface routex_egress_serializer_if;
    import routex_egress_serializer_pkg::*;

    flit_t       d;
    logic        d_valid;
    logic        d_sof;
    logic        d_bp;
    logic [63:0] q;
    logic        q_valid;
    logic        q_sof;
    logic        q_eof;
    logic        q_bp;
    logic        overflow;
    logic        err;

    modport master (
        output d, d_valid, d_sof, q_bp,
        input  d_bp, q, q_valid, q_sof, q_eof, overflow, err
    );

    modport slave (
        input  d, d_valid, d_sof, q_bp,
        output d_bp, q, q_valid, q_sof, q_eof, overflow, err
    );

endinterface

// File: rtl/routex_egress_serializer_flit_fifo.sv
// Flit FIFO with extra-MSB pointers, combinational head and free-entry count.
// A pop on a full FIFO frees the slot the simultaneous write lands in.
module routex_egress_serializer_flit_fifo #(
    parameter int Width = 513,
    parameter int Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [Width-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [Width-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] free_o
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      used_s;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign used_s    = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (used_s == (AW+1)'(Depth));
    assign free_o    = (AW+1)'(Depth) - used_s;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_fire_s = wr_en_i && (!full_o || rd_en_i);
    assign rd_fire_s = rd_en_i && !empty_o;

    // Pointer update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_fire_s) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/routex_egress_serializer.sv
// Serializes 512-bit routex flits into 64-bit link words, trimming tail
// padding, with a small FIFO absorbing the core's backpressure latency.
module routex_egress_serializer
    import routex_egress_serializer_pkg::*;
#(
    parameter int Depth    = 4,
    parameter int BpMargin = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    routex_egress_serializer_if.slave  bus
);
    localparam int CW = $clog2(Depth) + 1;

    logic [FLIT_W:0] head_raw_s;
    flit_t           head_s;
    logic            head_sof_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   free_s;
    logic [CW-1:0]   free_next_s;
    logic            pop_s;
    logic            wr_ok_s;

    ser_state_t      state_q;
    logic [2:0]      idx_q;
    logic [LEN_W-1:0] rem_q;
    logic [63:0]     q_q;
    logic            q_valid_q;
    logic            q_sof_q;
    logic            q_eof_q;
    logic            err_q;
    logic            overflow_q;
    logic            d_bp_q;

    routex_egress_serializer_flit_fifo #(
        .Width (FLIT_W + 1),
        .Depth (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (bus.d_valid),
        .wr_data_i ({bus.d_sof, bus.d}),
        .rd_en_i   (pop_s),
        .head_o    (head_raw_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .free_o    (free_s)
    );

    assign head_s      = head_raw_s[FLIT_W-1:0];
    assign head_sof_s  = head_raw_s[FLIT_W];
    assign wr_ok_s     = bus.d_valid && (!full_s || pop_s);
    assign free_next_s = free_s + {{(CW-1){1'b0}}, pop_s} - {{(CW-1){1'b0}}, wr_ok_s};

    // Pop decision: must match the FSM's consumption of the head flit
    always_comb begin
        pop_s = 1'b0;
        if (!bus.q_bp && !empty_s) begin
            case (state_q)
                IDLE:    pop_s = !head_sof_s;
                HDR:     pop_s = (idx_q == 3'd7);
                PAY:     pop_s = !head_sof_s && ((rem_q == LEN_W'(1)) || (idx_q == 3'd7));
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sticky overflow and backpressure based on occupancy after this edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            d_bp_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (bus.d_valid & full_s & ~pop_s);
            d_bp_q     <= (free_next_s <= CW'(BpMargin));
        end
    end

    // Serializer FSM; IDLE emits header word 0 directly to save a cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            rem_q     <= '0;
            q_q       <= 64'd0;
            q_valid_q <= 1'b0;
            q_sof_q   <= 1'b0;
            q_eof_q   <= 1'b0;
            err_q     <= 1'b0;
        end else if (bus.q_bp) begin
            err_q <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            q_sof_q   <= 1'b0;
            q_eof_q   <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_s) begin
                        if (head_sof_s) begin
                            q_q       <= head_s[0];
                            q_valid_q <= 1'b1;
                            q_sof_q   <= 1'b1;
                            idx_q     <= 3'd1;
                            rem_q     <= flit_len(head_s);
                            state_q   <= HDR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (!empty_s) begin
                        q_q       <= head_s[idx_q];
                        q_valid_q <= 1'b1;
                        q_sof_q   <= (idx_q == 3'd0);
                        idx_q     <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            if (rem_q == '0) begin
                                q_eof_q <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= PAY;
                            end
                        end
                    end
                end
                PAY: begin
                    if (!empty_s) begin
                        if (head_sof_s) begin
                            // Truncated packet: abandon it without EOF, restart on the new header
                            err_q   <= 1'b1;
                            idx_q   <= 3'd0;
                            rem_q   <= flit_len(head_s);
                            state_q <= HDR;
                        end else begin
                            q_q       <= head_s[idx_q];
                            q_valid_q <= 1'b1;
                            rem_q     <= rem_q - LEN_W'(1);
                            if (rem_q == LEN_W'(1)) begin
                                q_eof_q <= 1'b1;
                                idx_q   <= 3'd0;
                                state_q <= IDLE;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q        = q_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.q_sof    = q_sof_q;
    assign bus.q_eof    = q_eof_q;
    assign bus.err      = err_q;
    assign bus.overflow = overflow_q;
    assign bus.d_bp     = d_bp_q;

endmodule
